// File: rtl/onchip_mem_copy_master.sv
// Word-serial block copy master for a single-port on-chip RAM (read, wait, write per word).
// Define ONCHIP_MEM_COPY_CHECKSUM_EN to add a running sum of the copied words on the checksum output.
module onchip_mem_copy_master #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [ADDR_W-1:0]     dst_addr,
   input  logic [ADDR_W:0]       len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W:0]       words_left,
   output logic [ADDR_W-1:0]     avm_address,
   output logic [DATA_W/8-1:0]   avm_byteenable,
   output logic                  avm_chipselect,
   output logic                  avm_write,
   output logic [DATA_W-1:0]     avm_writedata,
   output logic                  avm_clken,
   input  logic [DATA_W-1:0]     avm_readdata
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]     checksum
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_FIN} state_t;

   localparam logic [1:0]      LAT_LAST = 2'(READ_LATENCY - 1);
   localparam logic [ADDR_W-1:0] ONE_A  = 1;
   localparam logic [ADDR_W:0]   ONE_L  = 1;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_src, r_dst, w_src_nxt, w_dst_nxt;
   logic [ADDR_W:0]     r_left, w_left_nxt;
   logic [1:0]          r_lat, w_lat_nxt;
   logic [DATA_W-1:0]   r_data, w_data_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic                r_cs, r_we, r_busy, r_done;
   logic                w_cs_nxt, w_we_nxt, w_busy_nxt, w_done_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_left  <= '0;
         r_lat   <= '0;
         r_data  <= '0;
         r_addr  <= '0;
         r_cs    <= 1'b0;
         r_we    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_src   <= w_src_nxt;
         r_dst   <= w_dst_nxt;
         r_left  <= w_left_nxt;
         r_lat   <= w_lat_nxt;
         r_data  <= w_data_nxt;
         r_addr  <= w_addr_nxt;
         r_cs    <= w_cs_nxt;
         r_we    <= w_we_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Bus outputs are decoded from the next state so they are registered and
   // line up with the cycle of the state they belong to.
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      w_left_nxt  = r_left;
      w_lat_nxt   = r_lat;
      w_data_nxt  = r_data;
      w_addr_nxt  = r_addr;
      w_cs_nxt    = 1'b0;
      w_we_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_src_nxt  = src_addr;
               w_dst_nxt  = dst_addr;
               w_left_nxt = len;
               if (len == '0) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_state_nxt = S_READ;
                  w_cs_nxt    = 1'b1;
                  w_addr_nxt  = src_addr;
               end
            end
         end
         S_READ: begin
            w_state_nxt = S_WAIT;
            w_lat_nxt   = '0;
         end
         S_WAIT: begin
            if (r_lat == LAT_LAST) begin
               w_data_nxt  = avm_readdata;
               w_state_nxt = S_WRITE;
               w_cs_nxt    = 1'b1;
               w_we_nxt    = 1'b1;
               w_addr_nxt  = r_dst;
            end else begin
               w_lat_nxt = r_lat + 2'd1;
            end
         end
         S_WRITE: begin
            w_src_nxt  = r_src + ONE_A;
            w_dst_nxt  = r_dst + ONE_A;
            w_left_nxt = r_left - ONE_L;
            if (r_left == ONE_L) begin
               w_state_nxt = S_FIN;
            end else begin
               w_state_nxt = S_READ;
               w_cs_nxt    = 1'b1;
               w_addr_nxt  = r_src + ONE_A;
            end
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt == S_READ) || (w_state_nxt == S_WAIT) ||
                   (w_state_nxt == S_WRITE);
      w_done_nxt = (w_state_nxt == S_FIN);
   end

`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge clk) begin
      if (reset)
         r_checksum <= '0;
      else if (r_state == S_IDLE && start)
         r_checksum <= '0;
      else if (r_state == S_WRITE)
         r_checksum <= r_checksum + r_data;
   end

   assign checksum = r_checksum;
`endif

   assign busy           = r_busy;
   assign done           = r_done;
   assign words_left     = r_left;
   assign avm_address    = r_addr;
   assign avm_byteenable = '1;
   assign avm_chipselect = r_cs;
   assign avm_write      = r_we;
   assign avm_writedata  = r_data;
   assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Bench for onchip_mem_copy_master: RAM slave model, array-level copy reference, directed and random copies.
module tb_onchip_mem_copy_master;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int RL = 1;
   localparam int DEPTH = 1 << AW;

   logic            clk, reset, start;
   logic [AW-1:0]   src_addr, dst_addr;
   logic [AW:0]     len;
   logic            busy, done;
   logic [AW:0]     words_left;
   logic [AW-1:0]   avm_address;
   logic [DW/8-1:0] avm_byteenable;
   logic            avm_chipselect, avm_write, avm_clken;
   logic [DW-1:0]   avm_writedata, avm_readdata;
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
   logic [DW-1:0]   checksum;
`endif

   onchip_mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .words_left(words_left),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_chipselect(avm_chipselect), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_clken(avm_clken),
      .avm_readdata(avm_readdata)
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM slave model plus bus monitor
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] rd_pipe [RL];
   int cyc = 0;
   int cs_cnt, wr_cnt, done_cnt, first_cs, done_cyc, start_cyc;
   int rd_q[$];
   int exp_rd[$];
   int n_vec = 0;
   int n_err = 0;

   always @(posedge clk) begin
      if (avm_chipselect && avm_write) begin
         mem[avm_address] = avm_writedata;
         wr_cnt++;
      end
      if (avm_chipselect && !avm_write) begin
         rd_pipe[0] <= mem[avm_address];
         rd_q.push_back(int'(avm_address));
      end
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (avm_chipselect) begin
         cs_cnt++;
         if (first_cs < 0) first_cs = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      cyc++;
   end
   assign avm_readdata = rd_pipe[RL-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: ascending word-serial copy over the whole array
   task automatic ref_copy(input int s, input int d, input int l, output logic [DW-1:0] sum);
      logic [AW-1:0] si, di;
      logic [DW-1:0] v;
      sum = '0;
      exp_rd.delete();
      for (int i = 0; i < l; i++) begin
         si = AW'(s + i);
         di = AW'(d + i);
         v  = ref_mem[si];
         ref_mem[di] = v;
         sum = sum + v;
         exp_rd.push_back(int'(si));
      end
   endtask

   function automatic int mem_mism();
      int m = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) m++;
      return m;
   endfunction

   function automatic int rd_mism();
      int m = (rd_q.size() > exp_rd.size()) ? rd_q.size() - exp_rd.size()
                                            : exp_rd.size() - rd_q.size();
      for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
         if (rd_q[i] != exp_rd[i]) m++;
      return m;
   endfunction

   task automatic clr_mon();
      rd_q.delete();
      cs_cnt = 0; wr_cnt = 0; done_cnt = 0; first_cs = -1; done_cyc = -1;
   endtask

   task automatic run_copy(input int s, input int d, input int l, input bit mid);
      logic [DW-1:0] exp_sum;
      int n;
      clr_mon();
      ref_copy(s, d, l, exp_sum);
      @(negedge clk);
      start = 1'b1; src_addr = AW'(s); dst_addr = AW'(d); len = (AW+1)'(l);
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0; src_addr = AW'($urandom); dst_addr = AW'($urandom); len = (AW+1)'($urandom);
      if (mid) begin
         repeat (3) @(negedge clk);
         start = 1'b1;
         src_addr = AW'($urandom); dst_addr = AW'($urandom);
         len = (AW+1)'($urandom_range(1, 9));
         @(negedge clk);
         start = 1'b0;
      end
      n = 0;
      while (done_cnt == 0 && n < l * (2 + RL) + 20) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("done_count", 64'(done_cnt), 64'd1);
      if (l > 0) begin
         chk("cycles_read_to_done", 64'(done_cyc - first_cs + 1), 64'(l * (2 + RL) + 1));
      end else begin
         chk("cycles_start_to_done", 64'(done_cyc - start_cyc + 1), 64'd2);
         chk("len0_no_access", 64'(cs_cnt), 64'd0);
      end
      chk("read_order", 64'(rd_mism()), 64'd0);
      chk("write_count", 64'(wr_cnt), 64'(l));
      chk("ram_contents", 64'(mem_mism()), 64'd0);
      chk("busy_after", 64'(busy), 64'd0);
      chk("words_left_after", 64'(words_left), 64'd0);
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
      chk("checksum", 64'(checksum), 64'(exp_sum));
`endif
   endtask

   initial begin
      logic [DW-1:0] dummy;
      reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      repeat (3) @(negedge clk);
      // reset asserted together with start: reset wins
      start = 1'b1; src_addr = 10'd3; len = 11'd2;
      @(negedge clk);
      start = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_words_left", 64'(words_left), 64'd0);
      chk("rst_address", 64'(avm_address), 64'd0);
      chk("rst_chipselect", 64'(avm_chipselect), 64'd0);
      chk("rst_write", 64'(avm_write), 64'd0);
      chk("rst_writedata", 64'(avm_writedata), 64'd0);
      chk("byteenable", 64'(avm_byteenable), 64'hF);
      chk("clken", 64'(avm_clken), 64'd1);
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
      chk("rst_checksum", 64'(checksum), 64'd0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // basic copy of a known pattern
      for (int i = 0; i < 4; i++) begin
         mem[i] = 32'h11 * (i + 1);
         ref_mem[i] = mem[i];
      end
      run_copy(0, 100, 4, 1'b0);
      chk("basic_word0", 64'(mem[100]), 64'h11);
      chk("basic_word3", 64'(mem[103]), 64'h44);
      chk("basic_cycles13", 64'(done_cyc - first_cs + 1), 64'd13);
`ifdef ONCHIP_MEM_COPY_CHECKSUM_EN
      chk("basic_checksum_aa", 64'(checksum), 64'hAA);
`endif

      // zero length
      run_copy(5, 6, 0, 1'b0);

      // address wrap on the source side
      run_copy(1022, 10, 4, 1'b0);
      chk("wrap_third_read", 64'(rd_q.size() > 2 ? rd_q[2] : -1), 64'd0);

      // overlapping forward copy propagates the first word
      mem[0] = 32'hDEAD; ref_mem[0] = 32'hDEAD;
      run_copy(0, 1, 3, 1'b0);
      chk("overlap_word3", 64'(mem[3]), 64'hDEAD);

      // start while busy is ignored
      run_copy(400, 500, 6, 1'b1);

      // reset during the wait of word 2 of a 5-word copy
      clr_mon();
      ref_copy(200, 300, 1, dummy);
      @(negedge clk);
      start = 1'b1; src_addr = 10'd200; dst_addr = 10'd300; len = 11'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_reads", 64'(rd_q.size()), 64'd2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_chipselect", 64'(avm_chipselect), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_words_left", 64'(words_left), 64'd0);
      repeat (20) @(negedge clk);
      chk("midrst_no_done", 64'(done_cnt), 64'd0);
      chk("midrst_writes", 64'(wr_cnt), 64'd1);
      chk("midrst_ram", 64'(mem_mism()), 64'd0);
      run_copy(600, 700, 5, 1'b0);

      // random copies, including a full-depth one
      for (int k = 0; k < 6; k++)
         run_copy(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(1, 40)), 1'b0);
      run_copy(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), DEPTH, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
